// File: rtl/beep_pattern_timer_pkg.sv
// Shared alarm-path definitions: beep sequencer state encoding, default
// widths and the standard alarm beep pattern lengths (in prescaler ticks).
package beep_pattern_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_REP_W     = 4;

    localparam int PAT_ALARM_ON  = 3;
    localparam int PAT_ALARM_OFF = 2;

endpackage

// File: rtl/beep_pattern_timer_tick_down_counter.sv
// Loadable down-counter clocked by a timebase strobe. 'last' flags the tick
// that consumes the final count, so a phase loaded with N lasts N ticks.
module beep_pattern_timer_tick_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Load wins over tick; the count holds at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign count = r_count;
    assign last  = tick & (r_count == ONE);

endmodule

// File: rtl/beep_pattern_timer.sv
// Programmable on/off beep sequencer: runtime on/off lengths, finite or
// continuous burst count, stop abort and a natural-completion pulse.
module beep_pattern_timer
    import beep_pattern_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [REP_W-1:0] reps,
    output logic             beep,
    output logic             busy,
    output logic             done
);

    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_on_len;
    logic [CNT_W-1:0]   r_off_len;
    logic [REP_W-1:0]   r_reps;
    logic [REP_W-1:0]   r_burst;
    logic [REP_W-1:0]   w_burst_nxt;
    logic [REP_W-1:0]   w_burst_inc;
    logic               w_latch;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic [CNT_W-1:0]   w_phase_cnt;
    logic               w_cnt_zero;
    logic               w_last;
    logic               w_finish;
    logic               r_beep;
    logic               r_busy;
    logic               r_done;
    logic               w_beep_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    beep_pattern_timer_tick_down_counter #(
        .W(CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .tick     (tick),
        .count    (w_phase_cnt),
        .last     (w_last)
    );

    // A zero count inside an active phase is unreachable (lengths are
    // checked non-zero before loading); treat it as an abort, not a hang.
    assign w_cnt_zero  = (w_phase_cnt == '0);

    // Saturating so continuous mode never wraps back into a reps match.
    assign w_burst_inc = (r_burst == '1) ? r_burst : (r_burst + REP_ONE);

    // State, burst counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
            r_beep  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_burst <= w_burst_nxt;
            r_beep  <= w_beep_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Pattern configuration is captured only by an accepted start.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_on_len  <= on_len;
            r_off_len <= off_len;
            r_reps    <= reps;
        end
    end

    // Next state and phase-counter control; stop outranks start and tick.
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = r_on_len;
        w_burst_nxt = r_burst;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_latch = 1'b1;
                    if (on_len == '0) begin
                        w_finish = 1'b1;
                    end else begin
                        w_next      = ST_ON;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = on_len;
                        w_burst_nxt = '0;
                    end
                end
            end
            ST_ON: begin
                if (stop || w_cnt_zero) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_burst_nxt = w_burst_inc;
                    if ((r_reps != '0) && (w_burst_inc == r_reps)) begin
                        w_next   = ST_IDLE;
                        w_finish = 1'b1;
                    end else if (r_off_len != '0) begin
                        w_next     = ST_OFF;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = r_off_len;
                    end else begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = r_on_len;
                    end
                end
            end
            ST_OFF: begin
                if (stop || w_cnt_zero) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next     = ST_ON;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = r_on_len;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the flops show the new state.
    always_comb begin
        w_beep_nxt = (w_next == ST_ON);
        w_busy_nxt = (w_next != ST_IDLE);
        w_done_nxt = w_finish;
    end

    assign beep = r_beep;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_beep_pattern_timer.sv
// Scoreboard bench for beep_pattern_timer: per-cycle expected outputs come
// from a tick-count arithmetic model of the beep pattern.
module tb_beep_pattern_timer;
    import beep_pattern_timer_pkg::*;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;
    localparam int MAXN  = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [REP_W-1:0] reps;
    logic             beep;
    logic             busy;
    logic             done;

    beep_pattern_timer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .on_len  (on_len),
        .off_len (off_len),
        .reps    (reps),
        .beep    (beep),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic beep;
        logic busy;
        logic done;
        int   cyc;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string scen_name = "reset";

    bit tk[MAXN];
    bit st[MAXN];
    bit sp[MAXN];
    int onl[MAXN];
    int offl[MAXN];
    int rpl[MAXN];
    bit eb[MAXN];
    bit ey[MAXN];
    bit ed[MAXN];

    task automatic check(string name, int cyc, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    endtask

    // Pattern model: after an accepted start, the count k of ticks since the
    // start decides everything: finished when k reaches the total pattern
    // length, otherwise ON when k mod (on+off) < on.
    function automatic void model(int n);
        bit active = 1'b0;
        bit fin    = 1'b0;
        int k      = 0;
        int tot    = 0;
        int per    = 1;
        int on     = 1;
        for (int c = 0; c < n; c++) begin
            eb[c] = 1'b0;
            ey[c] = 1'b0;
            ed[c] = 1'b0;
            if (!active) begin
                if (st[c] && !sp[c]) begin
                    if (onl[c] == 0) begin
                        ed[c] = 1'b1;
                    end else begin
                        active = 1'b1;
                        on     = onl[c];
                        per    = onl[c] + offl[c];
                        fin    = (rpl[c] != 0);
                        tot    = rpl[c] * onl[c] + (rpl[c] - 1) * offl[c];
                        k      = 0;
                        eb[c]  = 1'b1;
                        ey[c]  = 1'b1;
                    end
                end
            end else if (sp[c]) begin
                active = 1'b0;
            end else begin
                if (tk[c]) k++;
                if (fin && (k == tot)) begin
                    active = 1'b0;
                    ed[c]  = 1'b1;
                end else begin
                    ey[c] = 1'b1;
                    eb[c] = ((k % per) < on);
                end
            end
        end
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXN; c++) begin
            tk[c]   = 1'b0;
            st[c]   = 1'b0;
            sp[c]   = 1'b0;
            onl[c]  = $urandom_range(0, 6);
            offl[c] = $urandom_range(0, 4);
            rpl[c]  = $urandom_range(0, 5);
        end
    endtask

    // Drive one scenario; the final cycle always stops so the next starts idle.
    task automatic run(string name, int n);
        exp_t e;
        scen_name = name;
        st[n-1]   = 1'b0;
        sp[n-1]   = 1'b1;
        model(n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tick    = tk[c];
            start   = st[c];
            stop    = sp[c];
            on_len  = CNT_W'(onl[c]);
            off_len = CNT_W'(offl[c]);
            reps    = REP_W'(rpl[c]);
            e.beep  = eb[c];
            e.busy  = ey[c];
            e.done  = ed[c];
            e.cyc   = c;
            sb_q.push_back(e);
        end
        @(negedge clk);
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        #2;
        check({name, ".drain"}, n, sb_q.size(), 0);
    endtask

    // Monitor: one expected entry per cycle, compared just after the edge.
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                m = sb_q.pop_front();
                check({scen_name, ".beep"}, m.cyc, beep, m.beep);
                check({scen_name, ".busy"}, m.cyc, busy, m.busy);
                check({scen_name, ".done"}, m.cyc, done, m.done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int tp;
        rst     = 1'b1;
        tick    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        on_len  = '0;
        off_len = '0;
        reps    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.beep", 0, beep, 0);
        check("reset.busy", 0, busy, 0);
        check("reset.done", 0, done, 0);
        @(negedge clk);
        rst = 1'b0;

        clear_stim();
        st[1] = 1'b1; onl[1] = PAT_ALARM_ON; offl[1] = PAT_ALARM_OFF; rpl[1] = 2;
        for (int c = 0; c < 50; c++) tk[c] = ((c % 4) == 3);
        run("alarm_3_2_x2", 50);

        clear_stim();
        st[1] = 1'b1; onl[1] = 2; offl[1] = 0; rpl[1] = 3;
        for (int c = 0; c < 40; c++) tk[c] = ((c % 3) == 2);
        run("on2_off0_x3", 40);

        clear_stim();
        st[0] = 1'b1; onl[0] = 1; offl[0] = 1; rpl[0] = 0;
        for (int c = 0; c <= 50; c++) tk[c] = 1'b1;
        sp[51] = 1'b1;
        run("continuous_stop", 60);

        clear_stim();
        st[2] = 1'b1; onl[2] = 0;
        st[3] = 1'b1; onl[3] = 0;
        st[6] = 1'b1; onl[6] = 0;
        for (int c = 0; c < 12; c++) tk[c] = $urandom_range(0, 1);
        run("on_len_zero", 12);

        clear_stim();
        st[1]  = 1'b1; onl[1]  = 4; offl[1]  = 3; rpl[1]  = 0;
        st[5]  = 1'b1; onl[5]  = 1; offl[5]  = 1; rpl[5]  = 1;
        st[30] = 1'b1; sp[30]  = 1'b1;
        st[35] = 1'b1; onl[35] = 1; offl[35] = 0; rpl[35] = 1;
        for (int c = 0; c < 50; c++) tk[c] = ((c % 2) == 0);
        run("retrigger_stop", 50);

        for (int r = 0; r < 25; r++) begin
            clear_stim();
            tp = $urandom_range(1, 4);
            for (int c = 0; c < 120; c++) begin
                tk[c] = ($urandom_range(1, tp) == 1);
                sp[c] = ($urandom_range(0, 59) == 0);
                st[c] = !sp[c] && ($urandom_range(0, 14) == 0);
            end
            run("random", 120);
        end

        // Asynchronous reset while the pattern sits in its OFF phase.
        scen_name = "async_rst";
        @(negedge clk);
        start = 1'b1; on_len = 8'd1; off_len = 8'd3; reps = 4'd0; tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("async_rst.pre_beep", 0, beep, 0);
        check("async_rst.pre_busy", 0, busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.beep", 0, beep, 0);
        check("async_rst.busy", 0, busy, 0);
        check("async_rst.done", 0, done, 0);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("async_rst.post_busy", 0, busy, 0);

        clear_stim();
        st[1] = 1'b1; onl[1] = 1; offl[1] = 2; rpl[1] = 1;
        for (int c = 0; c < 15; c++) tk[c] = ((c % 3) == 0);
        run("after_rst", 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
